uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one 8-bit UART transmitter between `NUM_REQ` byte sources. It sits between requesters (command echo, status reporter, debug dump, and so on) and the transmitter's `Tx_Data`/`Tx_DataValid`/`TxDone` interface. It grants one requester at a time and holds that byte stable for the whole frame. It raises `Tx_DataValid` to start the frame and waits for `TxDone`. It forces a low gap on `Tx_DataValid` between frames so the transmitter's rising-edge detector re-arms. A watchdog recovers if a frame never completes.

---
 rtl/uart_tx_sched_pkg.sv | 20 ++
 rtl/uart_rr_arbiter.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 124 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Imported by the arbiter and the top-level scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitDone,
    StGap
  } sched_state_e;

  localparam int unsigned DefTimeoutCycles = 131072;
  localparam int unsigned DefGapCycles     = 2;

  // Index/counter width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Reusable by any scheduler that shares one resource between NUM_REQ sources.
module uart_rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IdW-1:0]     ptr,
  output logic               any_req,
  output logic [IdW-1:0]     grant_idx
);

  int unsigned idx;

  always_comb begin
    any_req   = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!any_req && req_valid[IdW'(idx)]) begin
        any_req   = 1'b1;
        grant_idx = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8-bit UART transmitter between NUM_REQ byte sources, round-robin,
// with a forced low gap on Tx_DataValid and a watchdog for frames that never finish.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned GAP_CYCLES     = DefGapCycles,
  localparam int unsigned IdW = idx_width(NUM_REQ)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [NUM_REQ-1:0]   Req_Valid,
  input  logic [8*NUM_REQ-1:0] Req_Data,
  output logic [NUM_REQ-1:0]   Req_Ready,
  output logic [7:0]           Tx_Data,
  output logic                 Tx_DataValid,
  input  logic                 TxDone,
  output logic [IdW-1:0]       Grant_Id,
  output logic                 Busy,
  output logic                 Frame_Done,
  output logic                 Timeout_Err
);

  localparam int unsigned WdW  = idx_width(TIMEOUT_CYCLES);
  localparam int unsigned GapW = idx_width(GAP_CYCLES);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [IdW-1:0]  IdLast  = IdW'(NUM_REQ - 1);

  sched_state_e    state_q;
  logic [IdW-1:0]  ptr_q;
  logic [WdW-1:0]  wd_cnt_q;
  logic [GapW-1:0] gap_cnt_q;
  logic            txdone_q;

  logic            any_req;
  logic [IdW-1:0]  grant_idx;
  logic [7:0]      sel_byte;
  logic            done_edge;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arbiter (
    .req_valid (Req_Valid),
    .ptr       (ptr_q),
    .any_req   (any_req),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_byte = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IdW'(i)) sel_byte = Req_Data[8*i +: 8];
    end
  end

  // A TxDone held high for several cycles must complete only one frame.
  assign done_edge = TxDone & ~txdone_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      wd_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      txdone_q     <= 1'b0;
      Req_Ready    <= '0;
      Tx_Data      <= 8'h00;
      Tx_DataValid <= 1'b0;
      Grant_Id     <= '0;
      Busy         <= 1'b0;
      Frame_Done   <= 1'b0;
      Timeout_Err  <= 1'b0;
    end else begin
      txdone_q    <= TxDone;
      Req_Ready   <= '0;
      Frame_Done  <= 1'b0;
      Timeout_Err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            Tx_Data   <= sel_byte;
            Grant_Id  <= grant_idx;
            Req_Ready <= NUM_REQ'(1) << grant_idx;
            ptr_q     <= (grant_idx == IdLast) ? '0 : grant_idx + IdW'(1);
            Busy      <= 1'b1;
            state_q   <= StLaunch;
          end
        end
        StLaunch: begin
          Tx_DataValid <= 1'b1;
          wd_cnt_q     <= '0;
          state_q      <= StWaitDone;
        end
        StWaitDone: begin
          if (done_edge) begin
            Tx_DataValid <= 1'b0;
            Frame_Done   <= 1'b1;
            gap_cnt_q    <= '0;
            state_q      <= StGap;
          end else if (wd_cnt_q == WdLast) begin
            Tx_DataValid <= 1'b0;
            Timeout_Err  <= 1'b1;
            gap_cnt_q    <= '0;
            state_q      <= StGap;
          end else begin
            wd_cnt_q <= wd_cnt_q + WdW'(1);
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            Busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: vector table, corner-case sequences and random traffic,
// with a simple transmitter model and a round-robin reference scoreboard.
module tb_uart_tx_scheduler;

  localparam int NR    = 4;
  localparam int TO    = 64;
  localparam int GAP   = 2;
  localparam int FRAME = 40;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic [NR-1:0]   Req_Valid;
  logic [8*NR-1:0] Req_Data;
  logic [NR-1:0]   Req_Ready;
  logic [7:0]      Tx_Data;
  logic            Tx_DataValid;
  logic            TxDone;
  logic [1:0]      Grant_Id;
  logic            Busy;
  logic            Frame_Done;
  logic            Timeout_Err;

  always #5 Clk = ~Clk;

  uart_tx_scheduler #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO),
    .GAP_CYCLES     (GAP)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Req_Valid    (Req_Valid),
    .Req_Data     (Req_Data),
    .Req_Ready    (Req_Ready),
    .Tx_Data      (Tx_Data),
    .Tx_DataValid (Tx_DataValid),
    .TxDone       (TxDone),
    .Grant_Id     (Grant_Id),
    .Busy         (Busy),
    .Frame_Done   (Frame_Done),
    .Timeout_Err  (Timeout_Err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Requesters
  logic [NR-1:0] pend;
  logic [7:0]    pbyte[NR];
  bit            sticky;

  // Transmitter model
  bit       tx_busy, dv_prev_tx, mute;
  int       tx_left, done_left, done_len;
  logic [7:0] sent_q[$];

  // Scoreboard
  int         m_ptr;
  int         grants_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] hold_byte;
  int         fd_cnt, te_cnt, low_run;
  bit         fd_prev, dv_prev_m, busy_prev, seen_frame;

  typedef struct {
    logic [NR-1:0] mask;
    logic [7:0]    base;
    bit            stk;
    int            nf;
    logic [7:0]    gl;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic drive();
    Req_Valid = pend;
    for (int i = 0; i < NR; i++) Req_Data[8*i +: 8] = pbyte[i];
  endtask

  task automatic tick();
    logic [NR-1:0]   pv;
    logic [8*NR-1:0] pd;
    logic            pr;
    int              g;
    pv = Req_Valid;
    pd = Req_Data;
    pr = Reset_n;
    @(posedge Clk);
    #1;
    if (!pr) begin
      m_ptr      = 0;
      seen_frame = 0;
      low_run    = 0;
    end else begin
      if (Req_Ready != '0) begin
        g = pick(pv, m_ptr);
        check("grant_onehot", 32'(Req_Ready), (g < 0) ? 32'd0 : (32'd1 << g));
        check("grant_from_idle", 32'(busy_prev), 0);
        if (g >= 0) begin
          check("grant_id", 32'(Grant_Id), g);
          check("grant_byte", 32'(Tx_Data), 32'(pd[8*g +: 8]));
          hold_byte = pd[8*g +: 8];
          grants_q.push_back(g);
          exp_q.push_back(hold_byte);
          m_ptr = (g + 1) % NR;
          if (!sticky) pend[g] = 1'b0;
        end
      end else if (Busy) begin
        check("data_stable", 32'(Tx_Data), 32'(hold_byte));
      end
      if (Frame_Done) begin
        fd_cnt++;
        check("fd_one_cycle", 32'(fd_prev), 0);
        check("fd_dv_low", 32'(Tx_DataValid), 0);
      end
      if (Timeout_Err) begin
        te_cnt++;
        check("te_not_with_fd", 32'(Frame_Done), 0);
      end
      if (Tx_DataValid && !dv_prev_m) begin
        if (seen_frame) check("gap_low_cycles", 32'(low_run >= GAP + 2), 1);
        seen_frame = 1;
      end
      if (Tx_DataValid) low_run = 0;
      else low_run++;
    end
    fd_prev   = Frame_Done;
    dv_prev_m = Tx_DataValid;
    busy_prev = Busy;
    // Transmitter: latches on a rising start level when idle, pulses TxDone at frame end.
    if (done_left > 0) done_left--;
    if (tx_busy) begin
      tx_left--;
      if (tx_left == 0) begin
        tx_busy   = 0;
        done_left = done_len;
      end
    end else if (Tx_DataValid && !dv_prev_tx) begin
      tx_busy = 1;
      tx_left = FRAME;
      sent_q.push_back(Tx_Data);
    end
    dv_prev_tx = Tx_DataValid;
    TxDone     = (done_left > 0) && !mute;
    drive();
  endtask

  task automatic clear_logs();
    grants_q.delete();
    exp_q.delete();
    sent_q.delete();
    fd_cnt = 0;
    te_cnt = 0;
  endtask

  task automatic do_reset();
    pend    = '0;
    sticky  = 0;
    Reset_n = 1'b0;
    drive();
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (Busy && k < bound);
    if (Busy) check("idle_reached", 32'(Busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_data"}, 32'(Tx_Data), 0);
    check({tag, "_tx_dv"}, 32'(Tx_DataValid), 0);
    check({tag, "_req_ready"}, 32'(Req_Ready), 0);
    check({tag, "_grant_id"}, 32'(Grant_Id), 0);
    check({tag, "_busy"}, 32'(Busy), 0);
    check({tag, "_frame_done"}, 32'(Frame_Done), 0);
    check({tag, "_timeout_err"}, 32'(Timeout_Err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int k, g, max_age;
    int age[NR];
    Reset_n  = 1'b0;
    TxDone   = 1'b0;
    pend     = '0;
    sticky   = 0;
    mute     = 0;
    done_len = 1;
    for (int i = 0; i < NR; i++) pbyte[i] = 8'h00;
    drive();
    tbl[0] = '{mask: 4'b0001, base: 8'h61, stk: 0, nf: 1, gl: 8'b00_00_00_00};
    tbl[1] = '{mask: 4'b1111, base: 8'hA0, stk: 0, nf: 4, gl: 8'b11_10_01_00};
    tbl[2] = '{mask: 4'b1010, base: 8'h50, stk: 1, nf: 4, gl: 8'b11_01_11_01};
    tbl[3] = '{mask: 4'b0110, base: 8'h10, stk: 0, nf: 2, gl: 8'b00_00_10_01};
    tbl[4] = '{mask: 4'b1100, base: 8'hC0, stk: 1, nf: 3, gl: 8'b00_10_11_10};

    // Reset state and single-request latency
    tick();
    do_reset();
    clear_logs();
    check_all_zero("reset");
    pend     = 4'b0001;
    pbyte[0] = 8'h61;
    drive();
    tick();
    check("lat_ready", 32'(Req_Ready), 32'b0001);
    check("lat_busy", 32'(Busy), 1);
    check("lat_dv_not_yet", 32'(Tx_DataValid), 0);
    tick();
    check("lat_ready_pulse", 32'(Req_Ready), 0);
    check("lat_dv", 32'(Tx_DataValid), 1);
    wait_idle(200);
    check("lat_frames", fd_cnt, 1);
    check("lat_sent_cnt", sent_q.size(), 1);
    if (sent_q.size() > 0) check("lat_sent_byte", 32'(sent_q[0]), 32'h61);

    // Vector table: held request patterns and the grant order they must produce
    for (int r = 0; r < 5; r++) begin
      do_reset();
      clear_logs();
      sticky = tbl[r].stk;
      for (int i = 0; i < NR; i++) pbyte[i] = tbl[r].base + 8'(i);
      pend = tbl[r].mask;
      drive();
      k = 0;
      while (fd_cnt < tbl[r].nf && k < 100 * tbl[r].nf) begin
        tick();
        k++;
      end
      pend   = '0;
      sticky = 0;
      drive();
      wait_idle(200);
      check("row_frames", fd_cnt, tbl[r].nf);
      check("row_grants", grants_q.size(), tbl[r].nf);
      check("row_sent", sent_q.size(), tbl[r].nf);
      for (int j = 0; j < tbl[r].nf; j++) begin
        g = int'(tbl[r].gl[2*j +: 2]);
        if (j < grants_q.size()) check("row_grant_order", grants_q[j], g);
        if (j < sent_q.size()) check("row_byte_order", 32'(sent_q[j]), 32'(tbl[r].base + 8'(g)));
      end
    end

    // Watchdog: TxDone never rises
    do_reset();
    clear_logs();
    mute     = 1;
    sticky   = 1;
    pend     = 4'b0001;
    pbyte[0] = 8'h33;
    drive();
    tick();
    tick();
    check("to_dv_up", 32'(Tx_DataValid), 1);
    k = 0;
    while (!Timeout_Err && k < 200) begin
      tick();
      k++;
    end
    check("to_cycles", k, TO);
    check("to_no_fd", fd_cnt, 0);
    k = 0;
    while (Req_Ready == '0 && k < 50) begin
      tick();
      k++;
    end
    check("to_regrant_delay", k, GAP + 1);
    sticky = 0;
    pend   = '0;
    mute   = 0;
    drive();
    wait_idle(300);
    check("to_err_count", te_cnt, 1);
    check("to_fd_after", fd_cnt, 1);

    // TxDone held high for three cycles completes one frame only
    do_reset();
    clear_logs();
    done_len = 3;
    pend     = 4'b0001;
    pbyte[0] = 8'h5A;
    drive();
    wait_idle(200);
    repeat (10) tick();
    check("long_done_fd", fd_cnt, 1);
    check("long_done_te", te_cnt, 0);
    done_len = 1;

    // Reset mid-frame, then requesters 2 and 0 pending
    do_reset();
    clear_logs();
    pbyte[0] = 8'h20;
    pbyte[2] = 8'h22;
    pend     = 4'b0100;
    drive();
    repeat (7) tick();
    Reset_n = 1'b0;
    tick();
    check_all_zero("midrst");
    Reset_n = 1'b1;
    pend    = 4'b0101;
    drive();
    tick();
    check("midrst_first_grant", 32'(Req_Ready), 32'b0001);
    check("midrst_first_id", 32'(Grant_Id), 0);
    k = 0;
    while (grants_q.size() < 3 && k < 400) begin
      tick();
      k++;
    end
    check("midrst_grants", grants_q.size(), 3);
    if (grants_q.size() == 3) check("midrst_second", grants_q[2], 2);
    wait_idle(300);

    // Random traffic against the scoreboard
    do_reset();
    clear_logs();
    max_age = 0;
    for (int i = 0; i < NR; i++) age[i] = 0;
    for (int t = 0; t < 3000; t++) begin
      done_len = $urandom_range(1, 3);
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 7) == 0) begin
          pend[i]  = 1'b1;
          pbyte[i] = 8'($urandom);
        end else if (pend[i] && $urandom_range(0, 63) == 0) begin
          pend[i] = 1'b0;
        end
      end
      drive();
      tick();
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) age[i]++;
        else age[i] = 0;
        if (age[i] > max_age) max_age = age[i];
      end
    end
    pend = '0;
    drive();
    wait_idle(300);
    check("rand_max_wait", 32'(max_age <= 300), 1);
    check("rand_frames", fd_cnt, grants_q.size());
    check("rand_timeouts", te_cnt, 0);
    check("rand_sent_cnt", sent_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < sent_q.size(); j++) begin
      check("rand_sent_byte", 32'(sent_q[j]), 32'(exp_q[j]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
